// File: rtl/rect_fill_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fill_pkg
//  Description : Screen geometry, colour constants and fill FSM encoding
//                shared by the paced drawing engines.
//  Revision    : 1.0  initial release
// ============================================================================
package fill_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

endpackage
`default_nettype wire

// File: rtl/rect_fill_engine_if.sv
`default_nettype none
// ============================================================================
//  Interface   : rect_fill_engine_if
//  Description : Command inputs and pixel-write outputs of the fill engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface rect_fill_engine_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                mode;
    logic [COLOUR_W-1:0] colour_in;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic                abort;
    logic                busy;
    logic                done;
    logic                plot;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;

    modport master (
        output start, mode, colour_in, x0, y0, w, h, abort,
        input  busy, done, plot, x_out, y_out, colour_out
    );

    modport slave (
        input  start, mode, colour_in, x0, y0, w, h, abort,
        output busy, done, plot, x_out, y_out, colour_out
    );
endinterface
`default_nettype wire

// File: rtl/rect_fill_engine_pace_ticker.sv
`default_nettype none
// ============================================================================
//  Module      : pace_ticker
//  Description : Down-counter that ticks once every PACE enabled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module pace_ticker #(
    parameter int PACE = 44
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load,
    input  wire logic en,
    output logic      tick
);
    localparam int            CW       = (PACE > 1) ? $clog2(PACE) : 1;
    localparam logic [CW-1:0] C_RELOAD = CW'(PACE - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_RELOAD;
        end else if (en) begin
            r_count <= (r_count == '0) ? C_RELOAD : r_count - CW'(1);
        end
    end

    assign tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_engine
//  Description : Paced full-screen / clipped-rectangle fill, one plot strobe
//                per pixel in raster order, with start/busy/done and abort.
//  Revision    : 1.0  initial release
// ============================================================================
module rect_fill_engine #(
    parameter int SCREEN_W = fill_pkg::SCREEN_W,
    parameter int SCREEN_H = fill_pkg::SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = fill_pkg::COLOUR_W,
    parameter int PACE     = 44
) (
    input  wire logic          clock,
    input  wire logic          reset,
    rect_fill_engine_if.slave  bus
);
    import fill_pkg::*;

    localparam logic [X_W:0] C_SW = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] C_SH = (Y_W + 1)'(SCREEN_H);

    state_t              r_state;
    state_t              w_next;
    logic [COLOUR_W-1:0] r_colour;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [X_W-1:0]      r_x_left;
    logic [X_W:0]        r_x_end;
    logic [Y_W:0]        r_y_end;

    logic [X_W:0] w_x_sum;
    logic [Y_W:0] w_y_sum;
    logic [X_W:0] w_x_end;
    logic [Y_W:0] w_y_end;
    logic         w_empty;
    logic         w_accept;
    logic         w_tick;
    logic         w_fire;
    logic         w_x_last;
    logic         w_y_last;

    // Region ends are formed one bit wide so x0+w cannot wrap before clipping
    assign w_x_sum  = {1'b0, bus.x0} + {1'b0, bus.w};
    assign w_y_sum  = {1'b0, bus.y0} + {1'b0, bus.h};
    assign w_x_end  = (w_x_sum > C_SW) ? C_SW : w_x_sum;
    assign w_y_end  = (w_y_sum > C_SH) ? C_SH : w_y_sum;
    assign w_empty  = bus.mode && ((bus.w == '0) || (bus.h == '0) ||
                                   ({1'b0, bus.x0} >= C_SW) ||
                                   ({1'b0, bus.y0} >= C_SH));
    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_fire   = (r_state == ST_RUN) && w_tick && !bus.abort;
    assign w_x_last = (({1'b0, r_x} + (X_W + 1)'(1)) == r_x_end);
    assign w_y_last = (({1'b0, r_y} + (Y_W + 1)'(1)) == r_y_end);

    pace_ticker #(
        .PACE (PACE)
    ) u_pace (
        .clk  (clock),
        .rst  (reset),
        .load (w_accept),
        .en   (r_state == ST_RUN),
        .tick (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next = w_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_next = ST_IDLE;
                end else if (w_fire && w_x_last && w_y_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_colour <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_x_left <= '0;
            r_x_end  <= '0;
            r_y_end  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_colour <= bus.colour_in;
                if (bus.mode) begin
                    r_x      <= bus.x0;
                    r_y      <= bus.y0;
                    r_x_left <= bus.x0;
                    r_x_end  <= w_x_end;
                    r_y_end  <= w_y_end;
                end else begin
                    r_x      <= '0;
                    r_y      <= '0;
                    r_x_left <= '0;
                    r_x_end  <= C_SW;
                    r_y_end  <= C_SH;
                end
            end else if (w_fire && !(w_x_last && w_y_last)) begin
                // Final pixel leaves x/y in place so they never reach the screen edge
                if (w_x_last) begin
                    r_x <= r_x_left;
                    r_y <= r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
        end
    end

    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.plot       = w_fire;
    assign bus.x_out      = r_x;
    assign bus.y_out      = r_y;
    assign bus.colour_out = r_colour;

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_fill_engine
//  Description : Scoreboard bench for rect_fill_engine (directed fills).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rect_fill_engine;
    import fill_pkg::*;

    localparam int PACE = 2;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rect_fill_engine_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    rect_fill_engine #(
        .SCREEN_W (160),
        .SCREEN_H (120),
        .X_W      (8),
        .Y_W      (7),
        .COLOUR_W (3),
        .PACE     (PACE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pix_t exp_q[$];
    pix_t e_pix;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   next_plot_cyc = 0;
    int   plots_seen = 0;
    int   done_lo = 0;
    int   done_hi = 0;
    bit   done_exp = 1'b0;
    bit   fill_done_pending = 1'b0;
    bit   mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops expected pixels on every plot and polices done timing
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.plot) begin
                plots_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d exp=none cyc=%0d",
                             bus.x_out, bus.y_out, bus.colour_out, cyc);
                end else begin
                    e_pix = exp_q.pop_front();
                    if (bus.x_out !== e_pix.x || bus.y_out !== e_pix.y || bus.colour_out !== e_pix.c) begin
                        failures++;
                        $display("FAIL plot_value got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                                 bus.x_out, bus.y_out, bus.colour_out, e_pix.x, e_pix.y, e_pix.c);
                    end
                    checks++;
                    if (cyc != next_plot_cyc) begin
                        failures++;
                        $display("FAIL plot_timing got cyc=%0d exp cyc=%0d", cyc, next_plot_cyc);
                    end
                    next_plot_cyc = cyc + PACE;
                    checks++;
                    if (bus.busy !== 1'b1) begin
                        failures++;
                        $display("FAIL plot_busy got busy=%0b exp busy=1", bus.busy);
                    end
                    if (exp_q.size() == 0 && fill_done_pending) begin
                        fill_done_pending = 1'b0;
                        done_exp = 1'b1;
                        done_lo  = cyc + 1;
                        done_hi  = cyc + 1;
                    end
                end
            end
            if (bus.done) begin
                checks++;
                if (!done_exp || cyc < done_lo || cyc > done_hi) begin
                    failures++;
                    $display("FAIL done_timing got done at cyc=%0d exp window=%0d..%0d expected=%0b",
                             cyc, done_lo, done_hi, done_exp);
                end
                done_exp = 1'b0;
            end else if (done_exp && cyc > done_hi) begin
                checks++;
                failures++;
                $display("FAIL missing_done got none exp by cyc=%0d", done_hi);
                done_exp = 1'b0;
            end
        end
    end

    task automatic push_rect(input int xs, input int xe, input int ys, input int ye,
                             input logic [2:0] c);
        pix_t p;
        for (int yy = ys; yy < ye; yy++) begin
            for (int xx = xs; xx < xe; xx++) begin
                p.x = xx[7:0];
                p.y = yy[6:0];
                p.c = c;
                exp_q.push_back(p);
            end
        end
    endtask

    // done_kind: 0 = no done (aborted), 1 = after last plot, 2 = empty region
    task automatic issue(input logic m, input logic [2:0] c, input logic [7:0] xx,
                         input logic [7:0] ww, input logic [6:0] yy, input logic [6:0] hh,
                         input int done_kind);
        @(posedge clock);
        #1;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.colour_in = c;
        bus.x0        = xx;
        bus.w         = ww;
        bus.y0        = yy;
        bus.h         = hh;
        next_plot_cyc = cyc + PACE;
        if (done_kind == 2) begin
            done_exp = 1'b1;
            done_lo  = cyc + 1;
            done_hi  = cyc + 2;
        end else if (done_kind == 1) begin
            fill_done_pending = 1'b1;
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            #1;
            ok = (exp_q.size() == 0) && !done_exp && !fill_done_pending;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s got pending=%0d exp pending=0", name, exp_q.size());
            exp_q.delete();
            done_exp = 1'b0;
            fill_done_pending = 1'b0;
        end
    endtask

    task automatic wait_plots(input int target, input int budget);
        for (int i = 0; i < budget && plots_seen < target; i++) begin
            @(negedge clock);
            #1;
        end
        if (plots_seen < target) begin
            checks++;
            failures++;
            $display("FAIL timeout_plots got plots=%0d exp plots=%0d", plots_seen, target);
        end
    endtask

    task automatic check_busy_low(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL %s got busy=%0b exp busy=0", name, bus.busy);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out, bus.colour_out} !== '0) begin
            failures++;
            $display("FAIL %s got busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d exp all zero",
                     name, bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out, bus.colour_out);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.colour_in = '0;
        bus.x0        = '0;
        bus.y0        = '0;
        bus.w         = '0;
        bus.h         = '0;
        bus.abort     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all_zero("reset_state");
        mon_en = 1'b1;

        // T1: full-screen clear, region inputs ignored
        push_rect(0, 160, 0, 120, BLACK);
        issue(1'b0, BLACK, 8'd33, 8'd7, 7'd44, 7'd9, 1);
        wait_quiet(19200 * PACE + 50, "t1");

        // T2: small rectangle
        push_rect(10, 13, 5, 7, 3'b101);
        issue(1'b1, 3'b101, 8'd10, 8'd3, 7'd5, 7'd2, 1);
        wait_quiet(100, "t2");

        // T3: rectangle clipped at bottom-right corner to 2x2
        push_rect(158, 160, 118, 120, WHITE);
        issue(1'b1, WHITE, 8'd158, 8'd5, 7'd118, 7'd5, 1);
        wait_quiet(100, "t3");

        // T4: empty regions
        issue(1'b1, 3'b010, 8'd20, 8'd0, 7'd20, 7'd4, 2);
        check_busy_low(3, "t4_w0_busy");
        wait_quiet(20, "t4a");
        issue(1'b1, 3'b010, 8'd200, 8'd4, 7'd10, 7'd4, 2);
        check_busy_low(3, "t4_x200_busy");
        wait_quiet(20, "t4b");
        issue(1'b1, 3'b011, 8'd5, 8'd4, 7'd120, 7'd3, 2);
        check_busy_low(3, "t4_y120_busy");
        wait_quiet(20, "t4c");

        // T5: abort on the cycle the 4th plot would fire
        base = plots_seen;
        push_rect(40, 43, 30, 31, 3'b110);
        issue(1'b1, 3'b110, 8'd40, 8'd3, 7'd30, 7'd2, 0);
        wait_plots(base + 3, 100);
        @(posedge clock);
        @(posedge clock);
        #1;
        bus.abort = 1'b1;
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        check_busy_low(1, "t5_busy_after_abort");
        repeat (8) @(negedge clock);
        push_rect(10, 13, 5, 7, 3'b001);
        issue(1'b1, 3'b001, 8'd10, 8'd3, 7'd5, 7'd2, 1);
        wait_quiet(100, "t5_restart");

        // T6a: start pulse while busy is ignored
        push_rect(50, 53, 60, 62, 3'b100);
        issue(1'b1, 3'b100, 8'd50, 8'd3, 7'd60, 7'd2, 1);
        repeat (2) @(posedge clock);
        #1;
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.colour_in = 3'b111;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        wait_quiet(100, "t6a");
        repeat (6) @(negedge clock);

        // T6b: reset mid-fill drops everything
        base = plots_seen;
        push_rect(20, 30, 20, 25, 3'b011);
        issue(1'b1, 3'b011, 8'd20, 8'd10, 7'd20, 7'd5, 1);
        wait_plots(base + 5, 100);
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        fill_done_pending = 1'b0;
        done_exp = 1'b0;
        check_all_zero("t6_reset_mid_fill");
        mon_en = 1'b1;
        repeat (10) @(negedge clock);
        push_rect(0, 2, 0, 1, WHITE);
        issue(1'b1, WHITE, 8'd0, 8'd2, 7'd0, 7'd1, 1);
        wait_quiet(50, "t6_after_reset");
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
